// File: rtl/traffic_sink_if.sv
// ----------------------------------------------------------------------------
// traffic_sink_if
//   Link between a router's ejection output port and its traffic sink.
//
//   Handshake: the link is credit based and has no ready signal. The router
//   may present a flit only while it holds a credit for that flit's VC. A flit
//   is present in every cycle where in_flit[0] = 1, and the sink takes it in
//   that cycle. For every flit it accepts, the sink later returns exactly one
//   credit, as a single-cycle cr_valid strobe with cr_vc naming the VC.
//
//   Signals:
//     in_flit  : flit from the router (bit 0 = present)
//     cr_valid : credit return strobe (one cycle per credit)
//     cr_vc    : VC that the returned credit belongs to
//   Modports:
//     master : router side (drives in_flit)
//     slave  : sink side (drives credits)
// ----------------------------------------------------------------------------
interface traffic_sink_if #(
    parameter int FLIT_W = 32,
    parameter int VC_W   = 2
) ();
    logic [FLIT_W-1:0] in_flit;
    logic              cr_valid;
    logic [VC_W-1:0]   cr_vc;

    modport master (output in_flit, input  cr_valid, input  cr_vc);
    modport slave  (input  in_flit, output cr_valid, output cr_vc);
endinterface

// File: rtl/traffic_sink.sv
// ----------------------------------------------------------------------------
// traffic_sink
//   Ejection-side endpoint for one router. It accepts flits from the router's
//   ejection port and tracks packet framing per VC with a two-state FSM. For
//   every accepted flit it returns one credit after a programmable delay. It
//   also counts flits and packets, keeps sticky protocol error flags, and
//   raises done once the expected number of packets has drained.
//
//   Flit layout: [0] valid, [1] head, [2] tail, [3+:VC_W] vc,
//                [3+VC_W+:DST_W] dst, remaining bits are payload.
//
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     i_cfg_load           : one-cycle pulse; loads config, clears stats
//     i_cfg_expected_pkts  : packets to receive before done
//     i_cfg_credit_delay   : credit latency in cycles (0 acts as 1)
//     bus                  : flit in / credit out (slave modport)
//     o_flit_count         : accepted flits (saturating)
//     o_pkt_count          : completed packets (saturating)
//     o_err                : sticky flags [0] no open packet, [1] head while
//                            open, [2] dst mismatch, [3] vc out of range
//     o_done               : expected packets drained, VCs idle, no credits
//                            pending
//     o_vc_busy            : per-VC FSM state (1 = BUSY), debug view
// ----------------------------------------------------------------------------
module traffic_sink #(
    parameter int RID    = 0,
    parameter int NUM_VC = 4,
    parameter int VC_W   = 2,
    parameter int DST_W  = 4,
    parameter int FLIT_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cfg_load,
    input  logic [CNT_W-1:0]     i_cfg_expected_pkts,
    input  logic [2:0]           i_cfg_credit_delay,
    traffic_sink_if.slave        bus,
    output logic [CNT_W-1:0]     o_flit_count,
    output logic [CNT_W-1:0]     o_pkt_count,
    output logic [3:0]           o_err,
    output logic                 o_done,
    output logic [NUM_VC-1:0]    o_vc_busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} vc_state_e;

    localparam int PIPE_D = 8;

    // ---------------- flit decode ----------------
    logic             w_valid;
    logic             w_head;
    logic             w_tail;
    logic [VC_W-1:0]  w_vc;
    logic [DST_W-1:0] w_dst;
    logic             w_vc_ok;
    logic             w_accept;

    // A flit that arrives together with cfg_load is dropped.
    assign w_valid  = bus.in_flit[0] & ~i_cfg_load;
    assign w_head   = bus.in_flit[1];
    assign w_tail   = bus.in_flit[2];
    assign w_vc     = bus.in_flit[3 +: VC_W];
    assign w_dst    = bus.in_flit[3 + VC_W +: DST_W];
    assign w_vc_ok  = (32'(w_vc) < 32'(NUM_VC));
    assign w_accept = w_valid & w_vc_ok;

    // ---------------- registers ----------------
    vc_state_e        r_state [NUM_VC];
    vc_state_e        w_state_nxt [NUM_VC];
    logic [CNT_W-1:0] r_flit_count;
    logic [CNT_W-1:0] r_pkt_count;
    logic [CNT_W-1:0] r_expected;
    logic [2:0]       r_delay;
    logic [3:0]       r_err;
    logic             r_done;
    logic             r_cfg_seen;
    logic [VC_W:0]    r_pipe [PIPE_D];    // {valid, vc}

    // ---------------- per-VC FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) r_state[v] <= ST_IDLE;
        end else if (i_cfg_load) begin
            for (int v = 0; v < NUM_VC; v++) r_state[v] <= ST_IDLE;
        end else begin
            for (int v = 0; v < NUM_VC; v++) r_state[v] <= w_state_nxt[v];
        end
    end

    // ---------------- per-VC FSM: next state ----------------
    // A head always (re)opens a packet; in BUSY a non-head flit continues
    // the packet. Either way a tail closes it. A non-head flit on an idle VC
    // leaves the VC idle.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_state_nxt[v] = r_state[v];
            if (w_accept && (w_vc == VC_W'(v))) begin
                if (w_head || (r_state[v] == ST_BUSY))
                    w_state_nxt[v] = w_tail ? ST_IDLE : ST_BUSY;
                else
                    w_state_nxt[v] = ST_IDLE;
            end
        end
    end

    // ---------------- per-VC FSM: outputs ----------------
    logic              w_cur_busy;
    logic              w_pkt_done;
    logic              w_err_nohead;
    logic              w_err_reopen;
    logic [NUM_VC-1:0] w_vc_busy;

    always_comb begin
        w_cur_busy = 1'b0;
        w_vc_busy  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_vc_busy[v] = (r_state[v] == ST_BUSY);
            if ((w_vc == VC_W'(v)) && (r_state[v] == ST_BUSY))
                w_cur_busy = 1'b1;
        end
        w_pkt_done   = w_accept & w_tail & (w_head | w_cur_busy);
        w_err_nohead = w_accept & ~w_head & ~w_cur_busy;
        w_err_reopen = w_accept & w_head & w_cur_busy;
    end

    assign o_vc_busy = w_vc_busy;

    // ---------------- credit delay pipe ----------------
    // Stage k holds a credit k+1 cycles after its acceptance edge, so the
    // output taps stage D-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_D; i++) r_pipe[i] <= '0;
        end else if (i_cfg_load) begin
            for (int i = 0; i < PIPE_D; i++) r_pipe[i] <= '0;
        end else begin
            for (int i = PIPE_D - 1; i > 0; i--) r_pipe[i] <= r_pipe[i-1];
            r_pipe[0] <= {w_accept, (w_accept ? w_vc : {VC_W{1'b0}})};
        end
    end

    logic [VC_W:0] w_cr_tap;
    assign w_cr_tap     = r_pipe[r_delay - 3'd1];
    assign bus.cr_valid = w_cr_tap[VC_W];
    assign bus.cr_vc    = w_cr_tap[VC_W-1:0];

    // Credits that will still emerge after this cycle. The credit on the
    // output now counts as returned, and stages past the tap are stale.
    logic w_pending;
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < PIPE_D; i++) begin
            if (((i + 1) < int'(r_delay)) && r_pipe[i][VC_W])
                w_pending = 1'b1;
        end
    end

    logic w_done_cond;
    assign w_done_cond = r_cfg_seen && (r_pkt_count == r_expected) &&
                         (w_vc_busy == '0) && !w_pending && !w_accept;

    // ---------------- counters, errors, config, done ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_count <= '0;
            r_pkt_count  <= '0;
            r_expected   <= '0;
            r_delay      <= 3'd1;
            r_err        <= '0;
            r_done       <= 1'b0;
            r_cfg_seen   <= 1'b0;
        end else if (i_cfg_load) begin
            r_expected   <= i_cfg_expected_pkts;
            r_delay      <= (i_cfg_credit_delay == 3'd0) ? 3'd1 : i_cfg_credit_delay;
            r_flit_count <= '0;
            r_pkt_count  <= '0;
            r_err        <= '0;
            r_cfg_seen   <= 1'b1;
            // All state is cleared here, so done only depends on the new target.
            r_done       <= (i_cfg_expected_pkts == '0);
        end else begin
            if (w_accept && (r_flit_count != {CNT_W{1'b1}}))
                r_flit_count <= r_flit_count + CNT_W'(1);
            if (w_pkt_done && (r_pkt_count != {CNT_W{1'b1}}))
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            r_err <= r_err | {w_valid & ~w_vc_ok,
                              w_valid & (w_dst != DST_W'(RID)),
                              w_err_reopen,
                              w_err_nohead};
            r_done <= w_done_cond;
        end
    end

    assign o_flit_count = r_flit_count;
    assign o_pkt_count  = r_pkt_count;
    assign o_err        = r_err;
    assign o_done       = r_done;

endmodule

// File: tb/tb_traffic_sink.sv
// ----------------------------------------------------------------------------
// tb_traffic_sink
//   Directed bench for traffic_sink. VC_W is 3 and NUM_VC is 4, so vc = 4 is
//   an out-of-range VC. A negedge monitor records every credit strobe with
//   its cycle number. The directed steps compare that record and the status
//   outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_traffic_sink;
    localparam int RID    = 5;
    localparam int NUM_VC = 4;
    localparam int VC_W   = 3;
    localparam int DST_W  = 4;
    localparam int FLIT_W = 32;
    localparam int CNT_W  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              cfg_load = 1'b0;
    logic [CNT_W-1:0]  cfg_exp  = '0;
    logic [2:0]        cfg_dly  = '0;
    logic [CNT_W-1:0]  flit_count;
    logic [CNT_W-1:0]  pkt_count;
    logic [3:0]        err;
    logic              done;
    logic [NUM_VC-1:0] vc_busy;

    traffic_sink_if #(.FLIT_W(FLIT_W), .VC_W(VC_W)) bus ();

    traffic_sink #(
        .RID(RID), .NUM_VC(NUM_VC), .VC_W(VC_W),
        .DST_W(DST_W), .FLIT_W(FLIT_W), .CNT_W(CNT_W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_cfg_load          (cfg_load),
        .i_cfg_expected_pkts (cfg_exp),
        .i_cfg_credit_delay  (cfg_dly),
        .bus                 (bus),
        .o_flit_count        (flit_count),
        .o_pkt_count         (pkt_count),
        .o_err               (err),
        .o_done              (done),
        .o_vc_busy           (vc_busy)
    );

    // ---------------- credit monitor ----------------
    int              cr_cyc_q[$];
    logic [VC_W-1:0] cr_vc_q[$];
    always @(negedge clk) begin
        if (bus.cr_valid === 1'b1) begin
            cr_cyc_q.push_back(cyc);
            cr_vc_q.push_back(bus.cr_vc);
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic h, input logic t,
                                             input int vc, input int dst);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[0] = 1'b1;
        f[1] = h;
        f[2] = t;
        f[3 +: VC_W] = VC_W'(vc);
        f[3 + VC_W +: DST_W] = DST_W'(dst);
        f[FLIT_W-1 -: 8] = 8'hA5;
        return f;
    endfunction

    task automatic load_cfg(input int exp_pkts, input int dly);
        cfg_exp  = CNT_W'(exp_pkts);
        cfg_dly  = 3'(dly);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic clear_mon();
        cr_cyc_q.delete();
        cr_vc_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    int t;
    logic [FLIT_W-1:0] seq [7];
    int                seq_vc [7];

    initial begin
        bus.in_flit = '0;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_cr_valid", 32'(bus.cr_valid), 0);
        chk("rst_flit_count", 32'(flit_count), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        tick(); tick();
        chk("done_before_cfg", 32'(done), 0);

        // 1: single-flit packet, delay 3
        load_cfg(1, 3);
        clear_mon();
        chk("t1_done_after_load", 32'(done), 0);
        t = cyc;
        bus.in_flit = mk(1, 1, 2, RID);
        tick();
        bus.in_flit = '0;
        chk("t1_pkt_count", 32'(pkt_count), 1);
        chk("t1_flit_count", 32'(flit_count), 1);
        tick(); tick();
        chk("t1_done_t3", 32'(done), 0);
        tick();
        chk("t1_done_t4", 32'(done), 1);
        chk("t1_err", 32'(err), 0);
        tick(); tick();
        chk("t1_cr_num", 32'(cr_cyc_q.size()), 1);
        if (cr_cyc_q.size() >= 1) begin
            chk("t1_cr_cycle", 32'(cr_cyc_q[0]), 32'(t + 3));
            chk("t1_cr_vc", 32'(cr_vc_q[0]), 2);
        end

        // 2: interleaved packets on vc 0 (4 flits) and vc 1 (3 flits), delay 1
        load_cfg(2, 1);
        clear_mon();
        seq[0] = mk(1, 0, 0, RID); seq_vc[0] = 0;
        seq[1] = mk(1, 0, 1, RID); seq_vc[1] = 1;
        seq[2] = mk(0, 0, 0, RID); seq_vc[2] = 0;
        seq[3] = mk(0, 0, 1, RID); seq_vc[3] = 1;
        seq[4] = mk(0, 0, 0, RID); seq_vc[4] = 0;
        seq[5] = mk(0, 1, 1, RID); seq_vc[5] = 1;
        seq[6] = mk(0, 1, 0, RID); seq_vc[6] = 0;
        t = cyc;
        for (int i = 0; i < 7; i++) begin
            bus.in_flit = seq[i];
            tick();
            if (i == 2) chk("t2_busy_mid", 32'(vc_busy), 32'h3);
        end
        bus.in_flit = '0;
        chk("t2_pkt_count", 32'(pkt_count), 2);
        chk("t2_flit_count", 32'(flit_count), 7);
        chk("t2_done_t7", 32'(done), 0);
        tick();
        chk("t2_done_t8", 32'(done), 1);
        chk("t2_err", 32'(err), 0);
        tick(); tick();
        chk("t2_cr_num", 32'(cr_cyc_q.size()), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < cr_cyc_q.size()) begin
                chk($sformatf("t2_cr_cycle_%0d", i), 32'(cr_cyc_q[i]), 32'(t + 1 + i));
                chk($sformatf("t2_cr_vc_%0d", i), 32'(cr_vc_q[i]), 32'(seq_vc[i]));
            end
        end

        // 3: protocol errors; expected = 0 gives done right after load
        load_cfg(0, 1);
        chk("t3_done_exp0", 32'(done), 1);
        clear_mon();
        t = cyc;
        bus.in_flit = mk(0, 0, 1, RID);          // body on idle vc 1
        tick();
        chk("t3_err0", 32'(err), 32'h1);
        bus.in_flit = mk(1, 0, 0, RID);          // head opens vc 0
        tick();
        chk("t3_err_head_ok", 32'(err), 32'h1);
        bus.in_flit = mk(1, 0, 0, RID);          // head again on open vc 0
        tick();
        chk("t3_err1", 32'(err), 32'h3);
        bus.in_flit = mk(0, 1, 0, RID + 1);      // tail with wrong dst
        tick();
        chk("t3_err2", 32'(err), 32'h7);
        chk("t3_pkt_count", 32'(pkt_count), 1);
        bus.in_flit = mk(1, 1, NUM_VC, RID);     // out-of-range vc
        tick();
        bus.in_flit = '0;
        chk("t3_err3", 32'(err), 32'hF);
        chk("t3_flit_count", 32'(flit_count), 4);
        chk("t3_done", 32'(done), 0);
        tick(); tick(); tick();
        chk("t3_cr_num", 32'(cr_cyc_q.size()), 4);
        if (cr_cyc_q.size() == 4) begin
            chk("t3_cr_last_cycle", 32'(cr_cyc_q[3]), 32'(t + 4));
            chk("t3_cr_last_vc", 32'(cr_vc_q[3]), 0);
        end

        // 4a: delay 0 behaves as delay 1
        load_cfg(1, 0);
        clear_mon();
        t = cyc;
        bus.in_flit = mk(1, 1, 3, RID);
        tick();
        bus.in_flit = '0;
        tick(); tick();
        chk("t4a_cr_num", 32'(cr_cyc_q.size()), 1);
        if (cr_cyc_q.size() >= 1)
            chk("t4a_cr_cycle", 32'(cr_cyc_q[0]), 32'(t + 1));

        // 4b: delay 7, 10 back-to-back single-flit packets
        load_cfg(10, 7);
        clear_mon();
        t = cyc;
        for (int i = 0; i < 10; i++) begin
            bus.in_flit = mk(1, 1, i % NUM_VC, RID);
            tick();
        end
        bus.in_flit = '0;
        chk("t4b_pkt_count", 32'(pkt_count), 10);
        for (int i = 0; i < 6; i++) tick();
        chk("t4b_done_t16", 32'(done), 0);
        tick();
        chk("t4b_done_t17", 32'(done), 1);
        tick();
        chk("t4b_cr_num", 32'(cr_cyc_q.size()), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < cr_cyc_q.size()) begin
                chk($sformatf("t4b_cr_cycle_%0d", i), 32'(cr_cyc_q[i]), 32'(t + 7 + i));
                chk($sformatf("t4b_cr_vc_%0d", i), 32'(cr_vc_q[i]), 32'(i % NUM_VC));
            end
        end

        // 5: reset while vc 3 is busy and 2 credits are in flight
        load_cfg(5, 5);
        clear_mon();
        bus.in_flit = mk(1, 0, 3, RID);
        tick();
        bus.in_flit = mk(0, 0, 3, RID);
        tick();
        bus.in_flit = '0;
        chk("t5_busy_before_rst", 32'(vc_busy), 32'h8);
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_no_credit", 32'(cr_cyc_q.size()), 0);
        chk("t5_flit_count", 32'(flit_count), 0);
        chk("t5_pkt_count", 32'(pkt_count), 0);
        chk("t5_err", 32'(err), 0);
        chk("t5_busy", 32'(vc_busy), 0);
        chk("t5_done", 32'(done), 0);
        bus.in_flit = mk(0, 0, 3, RID);
        tick();
        bus.in_flit = '0;
        chk("t5_err0_after_rst", 32'(err), 32'h1);

        // 6: cfg_load while a packet is open; the flit in the load cycle is dropped
        load_cfg(3, 1);
        bus.in_flit = mk(1, 0, 2, RID);
        tick();
        cfg_exp  = 16'd3;
        cfg_dly  = 3'd1;
        cfg_load = 1'b1;
        bus.in_flit = mk(0, 0, 2, RID);
        tick();
        cfg_load = 1'b0;
        bus.in_flit = '0;
        chk("t6_flit_count", 32'(flit_count), 0);
        chk("t6_pkt_count", 32'(pkt_count), 0);
        chk("t6_err", 32'(err), 0);
        chk("t6_busy", 32'(vc_busy), 0);
        bus.in_flit = mk(0, 1, 2, RID);
        tick();
        bus.in_flit = '0;
        chk("t6_err0", 32'(err), 32'h1);
        chk("t6_pkt_stays", 32'(pkt_count), 0);
        chk("t6_flit_count_tail", 32'(flit_count), 1);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_sink.md
Name: traffic_sink

Overview:
- Ejection-side endpoint for one router; one instance per router, mirroring the per-router traffic injector.
- Consumes flits leaving the router's ejection output port and reassembles them into packets per VC.
- Returns one credit per accepted flit to the router after a programmable delay.
- Keeps flit/packet counters, flags protocol errors, and raises done once the expected packet count has drained.

Parameters:
- RID, 0, this router's ID; compared against each flit's dst field.
- NUM_VC, 4, number of virtual channels (1..8).
- VC_W, 2, VC field width.
- DST_W, 4, destination field width.
- FLIT_W, 32, flit width, laid out as: [0] valid, [1] head, [2] tail, [3+:VC_W] vc, [3+VC_W+:DST_W] dst, remainder payload.
- CNT_W, 16, width of the counters and of the expected-packet register.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_load  in  1  one-cycle pulse; loads configuration and clears counters and errors.
- cfg_expected_pkts  in  CNT_W  number of packets to receive before done.
- cfg_credit_delay  in  3  credit return latency in cycles; 0 is treated as 1.
- in_flit  in  FLIT_W  flit from the router ejection port staging; flit present when bit 0 = 1.
- cr_valid  out  1  credit return strobe to the router ejection port.
- cr_vc  out  VC_W  VC of the returned credit.
- flit_count  out  CNT_W  accepted flits.
- pkt_count  out  CNT_W  completed packets (tail accepted).
- err  out  4  sticky error flags: [0] body/tail flit without open packet, [1] head while packet open, [2] dst != RID, [3] vc >= NUM_VC.
- done  out  1  high when pkt_count == expected, all VCs idle, and the credit pipe is empty.

Behaviour:
- Reset: all outputs 0, every per-VC FSM in IDLE, credit pipe cleared, expected = 0, delay = 1. done stays 0 after reset until the first cfg_load.
- Configuration:
  - cfg_load captures expected and delay.
  - It clears flit_count, pkt_count, err, per-VC FSMs and the credit pipe.
  - A flit arriving in the same cycle as cfg_load is dropped.
- Acceptance:
  - Every cycle with in_flit[0] = 1 and vc < NUM_VC, the flit is accepted.
  - flit_count increments by 1, saturating at all-ones.
  - A flit with vc >= NUM_VC sets err[3], is not counted, and earns no credit.
- Per-VC FSM (IDLE, BUSY):
  - IDLE + head + tail: single-flit packet; pkt_count +1; stays IDLE.
  - IDLE + head, no tail: go to BUSY.
  - IDLE + non-head: set err[0]; flit still counted and credited; stays IDLE.
  - BUSY + head: set err[1]; the flit restarts the packet. If it also has tail, pkt_count +1 and go to IDLE.
  - BUSY + tail: pkt_count +1; go to IDLE.
  - BUSY + body flit: stay in BUSY.
- Destination check: dst != RID sets err[2]. The flit is still processed normally.
- Credit return:
  - Each accepted flit enters an 8-deep delay shift pipe of {valid, vc}.
  - It emerges as cr_valid/cr_vc exactly D cycles after the acceptance edge, where D = max(cfg_credit_delay, 1).
  - At most one credit per cycle, because at most one flit arrives per cycle.
  - Credits for back-to-back flits appear on consecutive cycles.
- done:
  - Registered.
  - Asserts the cycle after its condition holds, and deasserts if a later flit arrives.
  - expected = 0 with no traffic gives done = 1 one cycle after cfg_load.
- Counters: pkt_count saturates. No wrap.
- err bits: sticky until cfg_load or reset.
- Reset mid-packet: FSMs return to IDLE and in-flight credits are discarded. The router side must be reset together with the sink.

Test Plan:
- Reset, then cfg_load (expected = 1, delay = 3); send single flit head = tail = 1, vc = 2, dst = RID at cycle t → cr_valid = 1 with cr_vc = 2 at t+3 only; pkt_count = 1, flit_count = 1; done = 1 at t+4; err = 0.
- cfg_load (expected = 2, delay = 1); send a 4-flit packet on vc 0 interleaved flit-by-flit with a 3-flit packet on vc 1 → pkt_count = 2 after the final tail, flit_count = 7; 7 credits on consecutive cycles with matching VCs; err = 0.
- Protocol errors: body flit on idle vc 1 → err[0]; head on vc 0, then head on vc 0 again → err[1]; dst = RID+1 → err[2]; vc = NUM_VC (requires NUM_VC < 2^VC_W) → err[3], no credit for it.
- cfg_credit_delay = 0 → credit at t+1. Then cfg_credit_delay = 7 with 10 back-to-back flits → 10 credits on t+7..t+16.
- Assert rst_n low while vc 3 is BUSY and 2 credits are in flight → no cr_valid afterwards; all counters = 0; a subsequent body flit on vc 3 sets err[0].
- cfg_load while a packet is open → counters and err = 0; the in-flight tail then sets err[0] and pkt_count stays 0.
